// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, buffers the
// returned word and presents its decoded fields to the decode stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_REQ   | request pending on imem, addr = pc
//   S_WAIT  | request accepted, waiting for the response
//   S_VALID | instruction in ibuf presented to decode
//   S_DRAIN | a redirect made the outstanding response stale; drop it
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        F_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] F_pc_o,
    output logic [6:0]  f_opcode_o,
    output logic [4:0]  f_rd_o,
    output logic [9:0]  f_funct_o,
    output logic [4:0]  f_rs1_o,
    output logic [4:0]  f_rs2_o,
    output logic [31:0] f_imm_o,
    output logic [2:0]  f_instr_type_o,
    output logic [31:0] f_default_pc_o,
    output logic [31:0] f_instr_o,
    output logic        f_commit_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] TY_NONE = 3'd0;
    localparam logic [2:0] TY_R    = 3'd1;
    localparam logic [2:0] TY_I    = 3'd2;
    localparam logic [2:0] TY_S    = 3'd3;
    localparam logic [2:0] TY_B    = 3'd4;
    localparam logic [2:0] TY_U    = 3'd5;
    localparam logic [2:0] TY_J    = 3'd6;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ibuf;
    logic [31:0] w_ibuf_nxt;
    logic [31:0] w_pc_plus4;
    logic        w_req;
    logic        w_commit;
    logic [31:0] w_instr;
    logic [2:0]  w_type;
    logic [31:0] w_imm;
    logic        w_unused_pc_lsb;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_ibuf  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ibuf  <= w_ibuf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ibuf_nxt  = r_ibuf;
        w_req       = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = 1'b1;
                if (imem_ready_i) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_ibuf_nxt  = imem_rdata_i;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                // consuming the instruction and requesting the next one share a cycle
                if (!F_stall_i) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_req       = 1'b1;
                    w_state_nxt = imem_ready_i ? S_WAIT : S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase

        if (redirect_i) begin
            w_req      = 1'b0;
            w_pc_nxt   = {redirect_pc_i[31:2], 2'b00};
            w_ibuf_nxt = r_ibuf;
            case (r_state)
                S_WAIT:  w_state_nxt = imem_rvalid_i ? S_REQ : S_DRAIN;
                S_DRAIN: w_state_nxt = S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    assign imem_req_o     = w_req & ~rst_i;
    assign imem_addr_o    = (r_state == S_VALID) ? w_pc_plus4 : r_pc;
    assign F_pc_o         = r_pc;
    assign f_default_pc_o = w_pc_plus4;

    // Every decoded field reads zero unless an instruction is being presented.
    assign w_commit   = (r_state == S_VALID);
    assign w_instr    = w_commit ? r_ibuf : 32'd0;
    assign f_commit_o = w_commit;
    assign f_instr_o  = w_instr;
    assign f_opcode_o = w_instr[6:0];
    assign f_rd_o     = w_instr[11:7];
    assign f_funct_o  = {w_instr[31:25], w_instr[14:12]};
    assign f_rs1_o    = w_instr[19:15];
    assign f_rs2_o    = w_instr[24:20];

    always_comb begin
        w_type = TY_NONE;
        w_imm  = '0;
        case (w_instr[6:0])
            7'b0110011:                                     w_type = TY_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_type = TY_I;
            7'b0100011:                                     w_type = TY_S;
            7'b1100011:                                     w_type = TY_B;
            7'b0110111, 7'b0010111:                         w_type = TY_U;
            7'b1101111:                                     w_type = TY_J;
            default:                                        w_type = TY_NONE;
        endcase
        case (w_type)
            TY_I: w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            TY_S: w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            TY_B: w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
            TY_U: w_imm = {w_instr[31:12], 12'd0};
            TY_J: w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                           w_instr[20], w_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign f_instr_type_o = w_type;
    assign f_imm_o        = w_imm;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory, a scoreboard of
// accepted fetches, and directed reset/stall/redirect scenarios.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        F_stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] F_pc_o;
    logic [6:0]  f_opcode_o;
    logic [4:0]  f_rd_o;
    logic [9:0]  f_funct_o;
    logic [4:0]  f_rs1_o;
    logic [4:0]  f_rs2_o;
    logic [31:0] f_imm_o;
    logic [2:0]  f_instr_type_o;
    logic [31:0] f_default_pc_o;
    logic [31:0] f_instr_o;
    logic        f_commit_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb_q[$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          mem_lat   = 1;
    int          flush_cnt = 0;
    logic [31:0] flush_pc  = RESET_PC;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .F_stall_i(F_stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .F_pc_o(F_pc_o),
        .f_opcode_o(f_opcode_o), .f_rd_o(f_rd_o), .f_funct_o(f_funct_o),
        .f_rs1_o(f_rs1_o), .f_rs2_o(f_rs2_o), .f_imm_o(f_imm_o),
        .f_instr_type_o(f_instr_type_o), .f_default_pc_o(f_default_pc_o),
        .f_instr_o(f_instr_o), .f_commit_o(f_commit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0050_0093;   // addi x1,x0,5
            32'h8000_0004: return 32'hFE00_0EE3;   // beq x0,x0,-4
            32'h8000_0008: return 32'h0011_2023;   // sw x1,0(x2)
            32'h8000_000C: return 32'h1234_52B7;   // lui x5,0x12345
            32'h8000_0010: return 32'h0080_00EF;   // jal x1,8
            32'h8000_0014: return 32'h0020_81B3;   // add x3,x1,x2
            32'h8000_0100: return 32'hFFFF_FFFF;   // illegal opcode
            default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        endcase
    endfunction

    function automatic logic [2:0] m_type(input logic [31:0] w);
        case (w[6:0])
            7'b0110011:                                     return 3'd1;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd2;
            7'b0100011:                                     return 3'd3;
            7'b1100011:                                     return 3'd4;
            7'b0110111, 7'b0010111:                         return 3'd5;
            7'b1101111:                                     return 3'd6;
            default:                                        return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        case (m_type(w))
            3'd2:    return {{20{w[31]}}, w[31:20]};
            3'd3:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd4:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd5:    return {w[31:12], 12'd0};
            3'd6:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // Instruction memory: one outstanding request, response mem_lat cycles after acceptance.
    initial begin : mem_model
        logic        acc;
        logic [31:0] a;
        logic [31:0] m_fetch_pc;
        int          cnt;
        int          seen_flush;
        bit          busy;
        imem_ready_i  = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        m_fetch_pc    = RESET_PC;
        busy = 0; cnt = 0; a = '0; seen_flush = 0;
        forever begin
            @(negedge clk_i);
            if (flush_cnt != seen_flush) begin
                seen_flush = flush_cnt;
                m_fetch_pc = flush_pc;
                sb_q.delete();
            end
            acc = imem_req_o && imem_ready_i;
            if (acc) begin
                a = imem_addr_o;
                chk_val("req_addr", imem_addr_o, m_fetch_pc);
                sb_q.push_back('{pc: m_fetch_pc, instr: mem_word(m_fetch_pc)});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            @(posedge clk_i);
            #1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
            if (acc) begin
                busy = 1;
                cnt  = mem_lat;
            end
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(a);
                    busy = 0;
                end
            end
            imem_ready_i = !busy;
        end
    end

    // Each consumed instruction must match the oldest live fetch.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && f_commit_o && !F_stall_i && !redirect_i) begin
                chk_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk_val("pc", F_pc_o, e.pc);
                    chk_val("instr", f_instr_o, e.instr);
                    chk_val("default_pc", f_default_pc_o, e.pc + 32'd4);
                    chk_val("type", 32'(f_instr_type_o), 32'(m_type(e.instr)));
                    chk_val("imm", f_imm_o, m_imm(e.instr));
                    chk_val("opcode", 32'(f_opcode_o), 32'(e.instr[6:0]));
                    chk_val("rd", 32'(f_rd_o), 32'(e.instr[11:7]));
                    chk_val("rs1", 32'(f_rs1_o), 32'(e.instr[19:15]));
                    chk_val("rs2", 32'(f_rs2_o), 32'(e.instr[24:20]));
                    chk_val("funct", 32'(f_funct_o), 32'({e.instr[31:25], e.instr[14:12]}));
                end
            end else if (!f_commit_o) begin
                chk_val("idle_zero", f_instr_o | f_imm_o | 32'(f_instr_type_o) | 32'(f_opcode_o)
                        | 32'(f_rd_o) | 32'(f_funct_o) | 32'(f_rs1_o) | 32'(f_rs2_o), 32'd0);
            end
        end
    end

    task automatic wait_commit(input string tag, input int max, output int waited);
        waited = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk_i);
            if (f_commit_o) begin
                waited = i;
                break;
            end
        end
        chk_val(tag, 32'(waited > 0), 32'd1);
    endtask

    task automatic wait_accept(input string tag, input int max);
        bit ok;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (imem_req_o && imem_ready_i) begin
                ok = 1;
                break;
            end
            @(negedge clk_i);
        end
        chk_val(tag, 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk_val("rst_req", 32'(imem_req_o), 32'd0);
        chk_val("rst_addr", imem_addr_o, RESET_PC);
        chk_val("rst_pc", F_pc_o, RESET_PC);
        chk_val("rst_def_pc", f_default_pc_o, RESET_PC + 32'd4);
        chk_val("rst_commit", 32'(f_commit_o), 32'd0);
        chk_val("rst_instr", f_instr_o, 32'd0);
    endtask

    initial begin : stim
        int          waited;
        int          stale;
        bit          found;
        logic [31:0] s_pc, s_instr, s_imm, s_def;
        logic [2:0]  s_type;
        rst_i = 1'b1; F_stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        repeat (3) @(negedge clk_i);
        chk_reset_vals();
        chk_val("rst_type", 32'(f_instr_type_o), 32'd0);
        chk_val("rst_imm", f_imm_o, 32'd0);

        // first fetch after reset release
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_val("first_req", 32'(imem_req_o), 32'd1);
        chk_val("first_addr", imem_addr_o, 32'h8000_0000);
        wait_commit("first_commit_seen", 10, waited);
        chk_val("first_latency", 32'(waited), 32'd2);
        chk_val("addi_opcode", 32'(f_opcode_o), 32'h13);
        chk_val("addi_rd", 32'(f_rd_o), 32'd1);
        chk_val("addi_imm", f_imm_o, 32'd5);
        chk_val("addi_type", 32'(f_instr_type_o), 32'd2);
        chk_val("addi_def_pc", f_default_pc_o, 32'h8000_0004);

        // back-to-back: commit on every second cycle
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_i);
            chk_val("b2b_pattern", 32'(f_commit_o), 32'(i % 2 == 0));
            if (i == 2) begin
                chk_val("beq_type", 32'(f_instr_type_o), 32'd4);
                chk_val("beq_imm", f_imm_o, 32'hFFFF_FFFC);
            end
        end

        // stall for 3 cycles while VALID
        @(posedge clk_i); #1 F_stall_i = 1'b1;
        wait_commit("stall_commit_seen", 10, waited);
        s_pc = F_pc_o; s_instr = f_instr_o; s_imm = f_imm_o; s_def = f_default_pc_o;
        s_type = f_instr_type_o;
        chk_val("stall_req0", 32'(imem_req_o), 32'd0);
        repeat (2) begin
            @(negedge clk_i);
            chk_val("stall_commit", 32'(f_commit_o), 32'd1);
            chk_val("stall_req", 32'(imem_req_o), 32'd0);
            chk_val("stall_pc", F_pc_o, s_pc);
            chk_val("stall_instr", f_instr_o, s_instr);
            chk_val("stall_imm", f_imm_o, s_imm);
            chk_val("stall_def_pc", f_default_pc_o, s_def);
            chk_val("stall_type", 32'(f_instr_type_o), 32'(s_type));
        end
        @(posedge clk_i); #1 F_stall_i = 1'b0;
        @(negedge clk_i);
        chk_val("unstall_req", 32'(imem_req_o), 32'd1);
        chk_val("unstall_addr", imem_addr_o, s_pc + 32'd4);
        mem_lat = 2;

        // redirect during WAIT; stale response must be drained
        @(posedge clk_i); #1;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0103;
        flush_pc = 32'h8000_0100; flush_cnt++;
        @(negedge clk_i);
        chk_val("redir_req_gated", 32'(imem_req_o), 32'd0);
        @(posedge clk_i); #1 redirect_i = 1'b0;
        stale = 0; found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (f_commit_o) stale++;
            if (imem_req_o) begin
                found = 1;
                break;
            end
        end
        chk_val("redir_req_seen", 32'(found), 32'd1);
        chk_val("redir_no_commit", 32'(stale), 32'd0);
        chk_val("redir_addr", imem_addr_o, 32'h8000_0100);
        chk_val("redir_pc", F_pc_o, 32'h8000_0100);
        wait_commit("illegal_commit_seen", 10, waited);
        chk_val("illegal_type", 32'(f_instr_type_o), 32'd0);
        chk_val("illegal_imm", f_imm_o, 32'd0);

        // redirect and stall together: redirect wins
        @(posedge clk_i); #1 F_stall_i = 1'b1;
        wait_commit("rs_commit_seen", 10, waited);
        @(posedge clk_i); #1;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
        flush_pc = 32'h8000_0200; flush_cnt++;
        @(negedge clk_i);
        chk_val("rs_req_gated", 32'(imem_req_o), 32'd0);
        @(posedge clk_i); #1 redirect_i = 1'b0; F_stall_i = 1'b0;
        @(negedge clk_i);
        chk_val("rs_discard", 32'(f_commit_o), 32'd0);
        chk_val("rs_pc", F_pc_o, 32'h8000_0200);
        mem_lat = 3;

        // reset mid-WAIT with a late response
        wait_accept("rst_accept_seen", 10);
        @(posedge clk_i); #1;
        rst_i = 1'b1; flush_pc = RESET_PC; flush_cnt++;
        @(negedge clk_i);
        chk_reset_vals();
        @(posedge clk_i); #1 rst_i = 1'b0;
        wait_commit("restart_commit_seen", 30, waited);
        chk_val("restart_pc", F_pc_o, RESET_PC);
        chk_val("restart_instr", f_instr_o, 32'h0050_0093);
        mem_lat = 1;

        // redirect to the top word; default pc wraps
        @(posedge clk_i); #1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        flush_pc = 32'hFFFF_FFFC; flush_cnt++;
        @(negedge clk_i);
        @(posedge clk_i); #1 redirect_i = 1'b0;
        @(negedge clk_i);
        chk_val("wrap_pc", F_pc_o, 32'hFFFF_FFFC);
        chk_val("wrap_def_pc", f_default_pc_o, 32'd0);
        wait_commit("wrap_commit_seen", 20, waited);
        chk_val("wrap_commit_pc", F_pc_o, 32'hFFFF_FFFC);
        wait_commit("wrap_next_seen", 20, waited);
        chk_val("wrap_next_pc", F_pc_o, 32'd0);

        repeat (6) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
